// File: rtl/bank_register_controller_pkg.sv
// Shared constants and state encoding for the bank register controller.
package bank_register_controller_pkg;

    localparam int SRW   = 4;
    localparam int OFFW  = 3;
    localparam int ADDR  = SRW + OFFW;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);
    localparam int IDXW  = $clog2(DEPTH);

    localparam logic [OFFW-1:0] CNT_LAST = '1;
    localparam logic [SRW-1:0]  GLOBAL_BANK = '0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/bank_register_controller_bank_stack.sv
// DEPTH x SRW LIFO holding saved bank numbers. The caller guarantees push
// only when not full and pop only when not empty, never both together.
module bank_stack
    import bank_register_controller_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic [SRW-1:0] push_data,
    input  logic           pop,
    output logic [SRW-1:0] top_data,
    output logic           full,
    output logic           empty
);

    logic [SRW-1:0] mem [DEPTH];
    logic [SPW-1:0] sp;
    logic [IDXW-1:0] top_idx;

    // Index of the most recently saved entry; only meaningful when not empty.
    always_comb begin
        top_idx = IDXW'(sp - SPW'(1));
    end

    assign top_data = mem[top_idx];
    assign full     = (sp == SPW'(DEPTH));
    assign empty    = (sp == '0);

    // Stack storage and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[sp[IDXW-1:0]] <= push_data;
            sp                <= sp + SPW'(1);
        end else if (pop) begin
            sp <= sp - SPW'(1);
        end
    end

endmodule

// File: rtl/bank_register_controller.sv
// Owns the bank/segment register (SR): direct loads, call-style push with
// optional clear of the new bank's registers, and return-style pop.
//
// Request semantics: push, pop and sr_wr_en are single-cycle strobes sampled
// on the rising clock edge while busy is low. There is no ready handshake;
// while busy is high every request is dropped, so the requester must hold
// off. Within one cycle pop beats push beats sr_wr_en; losers are dropped.
module bank_register_controller
    import bank_register_controller_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sr_wr_en,
    input  logic [SRW-1:0]  sr_wr_data,
    input  logic            push,
    input  logic [SRW-1:0]  push_data,
    input  logic            push_clear,
    input  logic            pop,
    input  logic            err_clr,
    output logic [SRW-1:0]  sr_value,
    output logic            busy,
    output logic            clr_we,
    output logic [ADDR-1:0] clr_addr,
    output logic            stack_full,
    output logic            stack_empty,
    output logic            ovf_err,
    output logic            unf_err
);

    state_t          state;
    logic [OFFW-1:0] cnt;
    logic [SRW-1:0]  sr;
    logic [SRW-1:0]  top_data;
    logic            idle;
    logic            do_pop;
    logic            do_push;
    logic            do_wr;
    logic            pop_unf;
    logic            push_ovf;
    logic            start_clear;

    // Request arbitration: only act while idle, pop > push > direct write.
    always_comb begin
        idle        = (state == IDLE);
        do_pop      = idle && pop && !stack_empty;
        pop_unf     = idle && pop && stack_empty;
        do_push     = idle && !pop && push && !stack_full;
        push_ovf    = idle && !pop && push && stack_full;
        do_wr       = idle && !pop && !push && sr_wr_en;
        start_clear = do_push && push_clear && (push_data != GLOBAL_BANK);
    end

    bank_stack u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (do_push),
        .push_data (sr),
        .pop       (do_pop),
        .top_data  (top_data),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // SR register: restore on pop, switch bank on push, or direct load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (do_pop) begin
            sr <= top_data;
        end else if (do_push) begin
            sr <= push_data;
        end else if (do_wr) begin
            sr <= sr_wr_data;
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (push_ovf) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
            if (pop_unf) begin
                unf_err <= 1'b1;
            end else if (err_clr) begin
                unf_err <= 1'b0;
            end
        end
    end

    // Clear sequencer: one write per register of the entered bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_clear) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + OFFW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sr_value = sr;
    assign busy     = (state == CLEAR);
    assign clr_we   = (state == CLEAR);
    assign clr_addr = {sr, cnt};

endmodule

// File: tb/tb_bank_register_controller.sv
// Directed bench for bank_register_controller with immediate-assertion checks.
module tb_bank_register_controller;

    logic       clk;
    logic       rst_n;
    logic       sr_wr_en;
    logic [3:0] sr_wr_data;
    logic       push;
    logic [3:0] push_data;
    logic       push_clear;
    logic       pop;
    logic       err_clr;
    logic [3:0] sr_value;
    logic       busy;
    logic       clr_we;
    logic [6:0] clr_addr;
    logic       stack_full;
    logic       stack_empty;
    logic       ovf_err;
    logic       unf_err;

    int n_checks = 0;
    int n_fail   = 0;

    bank_register_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sr_wr_en    (sr_wr_en),
        .sr_wr_data  (sr_wr_data),
        .push        (push),
        .push_data   (push_data),
        .push_clear  (push_clear),
        .pop         (pop),
        .err_clr     (err_clr),
        .sr_value    (sr_value),
        .busy        (busy),
        .clr_we      (clr_we),
        .clr_addr    (clr_addr),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then drop all request strobes.
    task automatic step();
        @(posedge clk);
        #1;
        sr_wr_en   = 1'b0;
        push       = 1'b0;
        push_clear = 1'b0;
        pop        = 1'b0;
        err_clr    = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        sr_wr_en   = 1'b0;
        sr_wr_data = 4'h0;
        push       = 1'b0;
        push_data  = 4'h0;
        push_clear = 1'b0;
        pop        = 1'b0;
        err_clr    = 1'b0;
        #12;

        // 1: reset values, then a direct load
        check("rst_sr", sr_value, 4'h0);
        check("rst_empty", stack_empty, 1'b1);
        check("rst_full", stack_full, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_clr_we", clr_we, 1'b0);
        check("rst_errs", {ovf_err, unf_err}, 2'b00);
        rst_n = 1'b1;
        step();
        check("idle_sr", sr_value, 4'h0);
        sr_wr_en = 1'b1; sr_wr_data = 4'h5;
        step();
        check("wr_sr", sr_value, 4'h5);

        // 2: push with clear, pop ignored while busy, pop afterwards
        push = 1'b1; push_data = 4'hA; push_clear = 1'b1;
        step();
        check("push_sr", sr_value, 4'hA);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("clr_busy%0d", i), busy, 1'b1);
            check($sformatf("clr_we%0d", i), clr_we, 1'b1);
            check($sformatf("clr_addr%0d", i), clr_addr, 7'h50 + 7'(i));
            if (i == 2) pop = 1'b1;
            step();
        end
        check("clr_done_busy", busy, 1'b0);
        check("clr_done_we", clr_we, 1'b0);
        check("busy_pop_ignored_sr", sr_value, 4'hA);
        check("busy_pop_ignored_empty", stack_empty, 1'b0);
        check("busy_pop_no_unf", unf_err, 1'b0);
        pop = 1'b1;
        step();
        check("pop_sr", sr_value, 4'h5);
        check("pop_empty", stack_empty, 1'b1);

        // 3: fill the stack, overflow, drain
        sr_wr_en = 1'b1; sr_wr_data = 4'h0;
        step();
        for (int i = 1; i <= 4; i++) begin
            push = 1'b1; push_data = 4'(i);
            step();
        end
        check("fill_full", stack_full, 1'b1);
        check("fill_sr", sr_value, 4'h4);
        check("fill_busy", busy, 1'b0);
        push = 1'b1; push_data = 4'h9; push_clear = 1'b1;
        step();
        check("ovf_err", ovf_err, 1'b1);
        check("ovf_sr", sr_value, 4'h4);
        check("ovf_full", stack_full, 1'b1);
        check("ovf_no_busy", busy, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            pop = 1'b1;
            step();
            check($sformatf("drain_sr%0d", i), sr_value, 4'(i));
        end
        check("drain_empty", stack_empty, 1'b1);

        // 4: underflow, clear, clear racing a new underflow
        pop = 1'b1;
        step();
        check("unf_err", unf_err, 1'b1);
        check("unf_sr", sr_value, 4'h0);
        err_clr = 1'b1;
        step();
        check("errclr_unf", unf_err, 1'b0);
        check("errclr_ovf", ovf_err, 1'b0);
        err_clr = 1'b1; pop = 1'b1;
        step();
        check("errclr_race_unf", unf_err, 1'b1);
        err_clr = 1'b1;
        step();

        // 5: pop beats push; push to the global bank never clears
        sr_wr_en = 1'b1; sr_wr_data = 4'h2;
        step();
        push = 1'b1; push_data = 4'h3;
        step();
        check("pre_race_sr", sr_value, 4'h3);
        push = 1'b1; push_data = 4'h7; pop = 1'b1;
        step();
        check("race_sr", sr_value, 4'h2);
        check("race_empty", stack_empty, 1'b1);
        push = 1'b1; push_data = 4'h0; push_clear = 1'b1; sr_wr_en = 1'b1; sr_wr_data = 4'hF;
        step();
        check("global_sr", sr_value, 4'h0);
        check("global_busy", busy, 1'b0);
        check("global_clr_we", clr_we, 1'b0);
        check("global_empty", stack_empty, 1'b0);

        // 6: asynchronous reset in the middle of a clear
        push = 1'b1; push_data = 4'hC; push_clear = 1'b1;
        step();
        step();
        step();
        step();
        check("mid_clr_addr", clr_addr, 7'h63);
        check("mid_busy", busy, 1'b1);
        check("mid_full", stack_full, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_clr_we", clr_we, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_sr", sr_value, 4'h0);
        check("arst_empty", stack_empty, 1'b1);
        #10;
        rst_n = 1'b1;
        step();
        check("post_rst_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
